// File: rtl/clint_irq_if.sv
// Register-access bus for clint_irq: a request held until a one-cycle ack,
// with read data valid while ack is high.
`timescale 1ns/1ps
interface clint_irq_if;
  logic        req;
  logic        wr;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, wr, addr, wdata, input rdata, ack);
  modport slave  (input req, wr, addr, wdata, output rdata, ack);
endinterface

// File: rtl/clint_irq.sv
// Core-local interruptor: msip register, prescaled 64-bit mtime with mtimecmp
// compare driving mtip, and a synchronized level/edge external interrupt.
`timescale 1ns/1ps
module clint_irq #(
  parameter int unsigned TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_in,
  input  logic        reset_in,
  clint_irq_if.slave  bus,
  input  logic        ext_src,
  output logic        msip,
  output logic        mtip,
  output logic        ext_irq
);

  localparam logic [2:0] A_MSIP     = 3'd0;
  localparam logic [2:0] A_CMP_LO   = 3'd1;
  localparam logic [2:0] A_CMP_HI   = 3'd2;
  localparam logic [2:0] A_TIME_LO  = 3'd3;
  localparam logic [2:0] A_TIME_HI  = 3'd4;
  localparam logic [2:0] A_EXT_CTRL = 3'd5;
  localparam logic [2:0] A_EXT_PEND = 3'd6;
  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t      r_state, w_state_nxt;
  logic        w_ack, w_access, w_wr, w_rd;
  logic [31:0] r_rdata, w_rd_val;

  logic        r_msip, r_mtip;
  logic [15:0] r_presc, w_presc_nxt;
  logic [63:0] r_mtime, w_mtime_nxt, r_mtimecmp;
  logic        w_tick;

  logic        r_sync1, r_sync2, r_sync3;
  logic        r_en, r_mode, r_pend, r_ext_irq;
  logic        w_en_nxt, w_mode_nxt, w_pend_nxt, w_ctrl_wr, w_clr, w_rise;

  // NOTE: every always_comb output is given a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = S_IDLE;
    w_ack       = 1'b0;
    case (r_state)
      S_IDLE: if (bus.req) w_state_nxt = S_ACK;
      S_ACK:  w_ack = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  assign w_access = (r_state == S_IDLE) && bus.req;
  assign w_wr     = w_access && bus.wr;
  assign w_rd     = w_access && !bus.wr;

  // A write to either mtime half wins over the tick; the other half is left alone.
  always_comb begin
    w_tick      = (r_presc == PRESC_MAX);
    w_presc_nxt = w_tick ? 16'd0 : r_presc + 16'd1;
    w_mtime_nxt = r_mtime;
    if (w_wr && bus.addr == A_TIME_LO)      w_mtime_nxt[31:0]  = bus.wdata;
    else if (w_wr && bus.addr == A_TIME_HI) w_mtime_nxt[63:32] = bus.wdata;
    else if (w_tick)                        w_mtime_nxt        = r_mtime + 64'd1;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_presc    <= 16'd0;
      r_mtime    <= 64'd0;
      r_mtimecmp <= MTIMECMP_RST;
      r_mtip     <= 1'b0;
      r_msip     <= 1'b0;
    end else begin
      r_presc <= w_presc_nxt;
      r_mtime <= w_mtime_nxt;
      r_mtip  <= (r_mtime >= r_mtimecmp);
      if (w_wr) begin
        case (bus.addr)
          A_MSIP:   r_msip            <= bus.wdata[0];
          A_CMP_LO: r_mtimecmp[31:0]  <= bus.wdata;
          A_CMP_HI: r_mtimecmp[63:32] <= bus.wdata;
          default:  ;
        endcase
      end
    end
  end

  assign w_rise    = r_sync2 && !r_sync3;
  assign w_ctrl_wr = w_wr && bus.addr == A_EXT_CTRL;
  assign w_en_nxt  = w_ctrl_wr ? bus.wdata[0] : r_en;
  assign w_mode_nxt = w_ctrl_wr ? bus.wdata[1] : r_mode;
  assign w_clr     = w_wr && bus.addr == A_EXT_PEND && bus.wdata[0];

  // A mode change flushes pending; in edge mode a new edge beats a coincident clear.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_mode_nxt != r_mode) w_pend_nxt = 1'b0;
    else if (!r_mode)         w_pend_nxt = r_sync2;
    else if (w_rise)          w_pend_nxt = 1'b1;
    else if (w_clr)           w_pend_nxt = 1'b0;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync3   <= 1'b0;
      r_en      <= 1'b0;
      r_mode    <= 1'b0;
      r_pend    <= 1'b0;
      r_ext_irq <= 1'b0;
    end else begin
      r_sync1   <= ext_src;
      r_sync2   <= r_sync1;
      r_sync3   <= r_sync2;
      r_en      <= w_en_nxt;
      r_mode    <= w_mode_nxt;
      r_pend    <= w_pend_nxt;
      r_ext_irq <= w_en_nxt && w_pend_nxt;
    end
  end

  always_comb begin
    w_rd_val = 32'd0;
    case (bus.addr)
      A_MSIP:     w_rd_val = {31'd0, r_msip};
      A_CMP_LO:   w_rd_val = r_mtimecmp[31:0];
      A_CMP_HI:   w_rd_val = r_mtimecmp[63:32];
      A_TIME_LO:  w_rd_val = r_mtime[31:0];
      A_TIME_HI:  w_rd_val = r_mtime[63:32];
      A_EXT_CTRL: w_rd_val = {30'd0, r_mode, r_en};
      A_EXT_PEND: w_rd_val = {31'd0, r_pend};
      default:    w_rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in)  r_rdata <= 32'd0;
    else if (w_rd)  r_rdata <= w_rd_val;
  end

  assign bus.ack   = w_ack;
  assign bus.rdata = r_rdata;
  assign msip      = r_msip;
  assign mtip      = r_mtip;
  assign ext_irq   = r_ext_irq;

endmodule

// File: tb/tb_clint_irq.sv
// Directed bench for clint_irq: u_dut runs TICK_DIV=1, u_dut_b runs TICK_DIV=4
// with mtimecmp resetting to 10 for the timer-from-reset scenario.
`timescale 1ns/1ps
module tb_clint_irq;

  logic clk, rst_n, ext_src;
  logic msip, mtip, ext_irq;
  logic msip_b, mtip_b, ext_irq_b;
  int   n_vec, n_err;

  clint_irq_if bus_a ();
  clint_irq_if bus_b ();

  clint_irq #(.TICK_DIV(1)) u_dut (
    .clk_in(clk), .reset_in(rst_n), .bus(bus_a.slave), .ext_src(ext_src),
    .msip(msip), .mtip(mtip), .ext_irq(ext_irq)
  );

  clint_irq #(.TICK_DIV(4), .MTIMECMP_RST(64'd10)) u_dut_b (
    .clk_in(clk), .reset_in(rst_n), .bus(bus_b.slave), .ext_src(1'b0),
    .msip(msip_b), .mtip(mtip_b), .ext_irq(ext_irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One access on bus_a; ack must follow on the first edge.
  task automatic xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                      output logic [31:0] rd);
    @(negedge clk);
    bus_a.req = 1'b1; bus_a.wr = w; bus_a.addr = a; bus_a.wdata = d;
    @(posedge clk); #1;
    check($sformatf("ack a%0d", a), bus_a.ack, 1'b1);
    rd = bus_a.rdata;
    @(negedge clk);
    bus_a.req = 1'b0;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] rd;
    xfer(1'b1, a, d, rd);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    xfer(1'b0, a, 32'd0, rd);
    check(tag, rd, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic ack_seen;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; ext_src = 1'b0;
    bus_a.req = 1'b0; bus_a.wr = 1'b0; bus_a.addr = 3'd0; bus_a.wdata = 32'd0;
    bus_b.req = 1'b0; bus_b.wr = 1'b0; bus_b.addr = 3'd0; bus_b.wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst ack",     bus_a.ack,   1'b0);
    check("rst rdata",   bus_a.rdata, 32'd0);
    check("rst msip",    msip,        1'b0);
    check("rst mtip",    mtip,        1'b0);
    check("rst ext_irq", ext_irq,     1'b0);
    check("rst b outs",  {msip_b, mtip_b, ext_irq_b}, 3'b000);
    @(negedge clk) rst_n = 1'b1;

    // Timer from reset on u_dut_b: mtime reaches 10 on edge 40, mtip on edge 41.
    repeat (40) @(posedge clk);
    #1 check("b mtip@40", mtip_b, 1'b0);
    @(negedge clk);
    bus_b.req = 1'b1; bus_b.wr = 1'b0; bus_b.addr = 3'd3;
    @(posedge clk); #1;
    check("b mtip@41", mtip_b, 1'b1);
    check("b ack rd",  bus_b.ack, 1'b1);
    check("b mtime",   bus_b.rdata, 32'd10);
    @(negedge clk) bus_b.req = 1'b0;
    @(negedge clk);
    bus_b.req = 1'b1; bus_b.wr = 1'b1; bus_b.addr = 3'd1; bus_b.wdata = 32'd100;
    @(posedge clk); #1;
    check("b ack wr", bus_b.ack, 1'b1);
    @(negedge clk) bus_b.req = 1'b0;
    @(posedge clk); #1;
    check("b mtip cmp100", mtip_b, 1'b0);

    // msip register
    wr_reg(3'd0, 32'd1);
    check("msip set", msip, 1'b1);
    rd_chk("rd msip", 3'd0, 32'h1);
    wr_reg(3'd0, 32'hFFFF_FFFE);
    check("msip clr", msip, 1'b0);
    wr_reg(3'd0, 32'hFFFF_FFFF);
    rd_chk("rd msip bits", 3'd0, 32'h1);
    wr_reg(3'd0, 32'd0);
    check("msip zero", msip, 1'b0);

    // mtimecmp halves and mtime wrap
    rd_chk("rd cmp_hi rst", 3'd2, 32'hFFFF_FFFF);
    wr_reg(3'd1, 32'h1234);
    rd_chk("rd cmp_lo", 3'd1, 32'h1234);
    check("mtip below cmp", mtip, 1'b0);
    wr_reg(3'd2, 32'd0);
    wr_reg(3'd1, 32'd5);
    wr_reg(3'd4, 32'hFFFF_FFFF);
    wr_reg(3'd3, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("mtip at max", mtip, 1'b1);
    @(posedge clk); #1;
    check("mtip after wrap", mtip, 1'b0);
    rd_chk("mtime_lo wrap", 3'd3, 32'd1);
    rd_chk("mtime_hi wrap", 3'd4, 32'd0);

    // reserved address
    wr_reg(3'd7, 32'hDEAD_BEEF);
    rd_chk("rd reserved", 3'd7, 32'd0);

    // Edge mode, enabled
    wr_reg(3'd5, 32'd3);
    rd_chk("rd ext_ctrl", 3'd5, 32'd3);
    check("edge idle irq", ext_irq, 1'b0);
    @(negedge clk) ext_src = 1'b1;
    @(posedge clk);
    @(negedge clk) ext_src = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("edge irq 3cyc", ext_irq, 1'b1);
    repeat (3) @(posedge clk);
    #1 check("edge irq hold", ext_irq, 1'b1);
    rd_chk("rd ext_pend", 3'd6, 32'd1);
    check("irq after read", ext_irq, 1'b1);
    wr_reg(3'd6, 32'd1);
    @(posedge clk); #1;
    check("edge clear", ext_irq, 1'b0);
    @(negedge clk) ext_src = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus_a.req = 1'b1; bus_a.wr = 1'b1; bus_a.addr = 3'd6; bus_a.wdata = 32'd1;
    @(posedge clk); #1;
    check("clr+edge ack", bus_a.ack, 1'b1);
    @(negedge clk) begin bus_a.req = 1'b0; ext_src = 1'b0; end
    repeat (2) @(posedge clk);
    #1 check("clr+edge irq", ext_irq, 1'b1);
    wr_reg(3'd6, 32'd1);

    // Level mode
    wr_reg(3'd5, 32'd0);
    @(negedge clk) ext_src = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("level en0 irq", ext_irq, 1'b0);
    rd_chk("level pend", 3'd6, 32'd1);
    wr_reg(3'd6, 32'd1);
    rd_chk("level pend ro", 3'd6, 32'd1);
    wr_reg(3'd5, 32'd1);
    @(posedge clk); #1;
    check("level en1 irq", ext_irq, 1'b1);
    @(negedge clk) ext_src = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("level drop", ext_irq, 1'b0);

    // Reset in the middle of an access with every output active
    @(negedge clk) ext_src = 1'b1;
    wr_reg(3'd4, 32'd0);
    wr_reg(3'd3, 32'd500);
    wr_reg(3'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("pre msip", msip, 1'b1);
    check("pre mtip", mtip, 1'b1);
    check("pre ext_irq", ext_irq, 1'b1);
    @(negedge clk);
    bus_a.req = 1'b1; bus_a.wr = 1'b0; bus_a.addr = 3'd3;
    @(posedge clk); #1;
    check("pre ack", bus_a.ack, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst ack",     bus_a.ack,   1'b0);
    check("arst rdata",   bus_a.rdata, 32'd0);
    check("arst msip",    msip,        1'b0);
    check("arst mtip",    mtip,        1'b0);
    check("arst ext_irq", ext_irq,     1'b0);
    @(negedge clk) begin bus_a.req = 1'b0; ext_src = 1'b0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus_a.ack) ack_seen = 1'b1;
    end
    check("no ack post rst", ack_seen, 1'b0);
    rd_chk("cmp_lo rst", 3'd1, 32'hFFFF_FFFF);
    rd_chk("cmp_hi rst", 3'd2, 32'hFFFF_FFFF);
    rd_chk("ext_ctrl rst", 3'd5, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clint_irq.md
CLINT_IRQ -- requirements
Module: clint_irq

Interface
REQ-001 Parameter TICK_DIV, default 1: clk_in cycles per mtime increment; legal range 1..65535.
REQ-002 Parameter MTIMECMP_RST, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp.
REQ-003 clk_in  input  1  sole clock; all state on its rising edge.
REQ-004 reset_in  input  1  reset, asynchronous and active-low: assert async, deassert synchronous to clk_in.
REQ-005 req  input  1  bus access request, held until ack.
REQ-006 wr  input  1  1 = write, 0 = read; valid while req=1.
REQ-007 addr  input  3  word offset: 0 msip, 1 mtimecmp_lo, 2 mtimecmp_hi, 3 mtime_lo, 4 mtime_hi, 5 ext_ctrl, 6 ext_pend, 7 reserved.
REQ-008 wdata  input  32  write data.
REQ-009 rdata  output  32  read data; valid when ack=1.
REQ-010 ack  output  1  one-cycle access-complete pulse.
REQ-011 ext_src  input  1  external interrupt line, asynchronous to clk_in.
REQ-012 msip  output  1  machine software interrupt pending; drives mip.msip.
REQ-013 mtip  output  1  machine timer interrupt pending; drives mip.mtip.
REQ-014 ext_irq  output  1  external interrupt request; drives the ext_irq input of the interrupt/mode logic.

Function
REQ-015 Handshake: FSM IDLE->ACK on req=1 in IDLE; ACK->IDLE unconditionally; ack=1 only in ACK; one access per two cycles minimum.
REQ-016 A write takes effect on the IDLE->ACK edge; a read samples the register on the same edge into rdata; rdata holds until the next read.
REQ-017 msip register: bit0 read/write; bits 31:1 read 0, writes ignored.
REQ-018 mtime: 64-bit counter; increments by 1 when the prescaler reaches TICK_DIV-1; prescaler then returns to 0; wraps 2^64-1 -> 0.
REQ-019 A write to mtime_lo or mtime_hi replaces that half and suppresses any increment in that cycle; the other half is unchanged; no carry is applied.
REQ-020 mtimecmp_lo/hi: 32-bit halves, read/write; no side effect on mtime.
REQ-021 mtip is registered: mtip <= (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on post-update values; 1-cycle latency after the change.
REQ-022 ext_src passes through a 2-flop synchronizer; the edge detector uses the second-stage output and a third flop.
REQ-023 ext_ctrl: bit0 enable (en), bit1 mode (0 level, 1 rising edge); other bits read 0.
REQ-024 Level mode: ext_pend bit0 = synchronized ext_src; writes to ext_pend ignored.
REQ-025 Edge mode: a synchronized rising edge sets ext_pend bit0; writing 1 to bit0 clears it; a simultaneous edge and clear leaves it set.
REQ-026 ext_irq = en & ext_pend bit0, registered; 3-cycle maximum latency from ext_src rise, excluding metastability.
REQ-027 Changing mode clears ext_pend in the same cycle.
REQ-028 Reserved address: reads return 0, writes ignored, ack still issued.
REQ-029 Interrupt outputs are level; no output is cleared by being read.

Reset
REQ-030 On reset_in=0: FSM=IDLE; ack=0; rdata=0; msip=0; mtime=0; prescaler=0; mtimecmp=MTIMECMP_RST; ext_ctrl=0; ext_pend=0; synchronizer flops=0; mtip=0; ext_irq=0.
REQ-031 Reset during ACK aborts the access; no ack is issued after release; a request still held after release is serviced as new.

Verification
REQ-032 Write msip=1 -> ack next cycle, msip=1; read addr 0 -> rdata=32'h1; write 0 -> msip=0.
REQ-033 TICK_DIV=4, mtimecmp=10, run from reset -> mtime=10 after 40 cycles; mtip rises exactly 1 cycle later; write mtimecmp_lo=100 -> mtip=0 next cycle.
REQ-034 Write mtime_hi=32'hFFFF_FFFF and mtime_lo=32'hFFFF_FFFF with TICK_DIV=1 -> next tick mtime=0, no carry out; mtip follows the compare.
REQ-035 Edge mode, en=1, pulse ext_src high for 1 cycle -> ext_irq=1 within 3 cycles and stays high; write ext_pend=1 -> ext_irq=0; a clear coinciding with an edge -> ext_irq stays 1.
REQ-036 Level mode, en=0, ext_src=1 -> ext_irq=0, ext_pend reads 1; set en=1 -> ext_irq=1; ext_src=0 -> ext_irq=0 within 3 cycles.
REQ-037 Assert reset_in mid-access with mtime=500 -> all outputs reach reset values immediately (asynchronous), no ack after release, mtimecmp reads all-ones.
